// File: rtl/alu_sched_pkg.sv
// Shared constants and state encoding for the round-robin ALU scheduler.
package alu_sched_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant from the valids and the
// priority bit, which moves to the loser whenever a grant is taken.
module rr_arb2
    import alu_sched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic a_valid,
    input  logic b_valid,
    output logic a_grant,
    output logic b_grant
);

    logic pri_reg;

    // pri_reg = ID_B means B wins a tie
    always_comb begin
        a_grant = en & a_valid & (~b_valid | (pri_reg == ID_A));
        b_grant = en & b_valid & (~a_valid | (pri_reg == ID_B));
    end

    // A grant is always an accept, so the winner drops to lowest priority here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pri_reg <= ID_A;
        end else if (a_grant | b_grant) begin
            pri_reg <= a_grant ? ID_B : ID_A;
        end
    end

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one registered ALU between requesters A and B.
// Optional ALU_FASTPATH_EN lets DONE grant a new operation when the result is taken.
module alu_rr_sched
    import alu_sched_pkg::*;
#(
    parameter int DW = 3,
    parameter int RW = 2 * DW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          A_VALID,
    output logic          A_READY,
    input  logic [DW-1:0] A_X,
    input  logic [DW-1:0] A_Y,
    input  logic [1:0]    A_OP,
    input  logic          B_VALID,
    output logic          B_READY,
    input  logic [DW-1:0] B_X,
    input  logic [DW-1:0] B_Y,
    input  logic [1:0]    B_OP,
    output logic          R_VALID,
    input  logic          R_READY,
    output logic [RW-1:0] R_Z,
    output logic          R_ID,
    output logic          BUSY
);

    state_t          state_reg, state_next;
    logic [DW-1:0]   x_reg, y_reg;
    logic [1:0]      op_reg;
    logic            id_reg;
    logic            r_valid_reg, r_valid_next;
    logic [RW-1:0]   r_z_reg, r_z_next;
    logic            r_id_reg, r_id_next;
    logic            grant_en, a_grant, b_grant, accept;
    logic [RW-1:0]   x_ext, y_ext, alu_z;

`ifdef ALU_FASTPATH_EN
    assign grant_en = (state_reg == ST_IDLE) | ((state_reg == ST_DONE) & R_READY);
`else
    assign grant_en = (state_reg == ST_IDLE);
`endif

    rr_arb2 u_arb (
        .clk     (CLK),
        .rst     (RST),
        .en      (grant_en),
        .a_valid (A_VALID),
        .b_valid (B_VALID),
        .a_grant (a_grant),
        .b_grant (b_grant)
    );

    assign accept = a_grant | b_grant;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            x_reg  <= '0;
            y_reg  <= '0;
            op_reg <= OP_ADD;
            id_reg <= ID_A;
        end else if (accept) begin
            x_reg  <= b_grant ? B_X  : A_X;
            y_reg  <= b_grant ? B_Y  : A_Y;
            op_reg <= b_grant ? B_OP : A_OP;
            id_reg <= b_grant ? ID_B : ID_A;
        end
    end

    // Zero-extend first so the product keeps all RW bits
    assign x_ext = {{(RW-DW){1'b0}}, x_reg};
    assign y_ext = {{(RW-DW){1'b0}}, y_reg};

    always_comb begin
        alu_z = '0;
        case (op_reg)
            OP_ADD:  alu_z = x_ext + y_ext;
            OP_MUL:  alu_z = x_ext * y_ext;
            OP_AND:  alu_z = x_ext & y_ext;
            OP_OR:   alu_z = x_ext | y_ext;
            default: alu_z = '0;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        r_valid_next = r_valid_reg;
        r_z_next     = r_z_reg;
        r_id_next    = r_id_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) state_next = ST_EXEC;
            end
            ST_EXEC: begin
                r_z_next     = alu_z;
                r_id_next    = id_reg;
                r_valid_next = 1'b1;
                state_next   = ST_DONE;
            end
            ST_DONE: begin
                // accept can only be high here when the fast path is built in
                if (R_READY) begin
                    r_valid_next = 1'b0;
                    state_next   = accept ? ST_EXEC : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg   <= ST_IDLE;
            r_valid_reg <= 1'b0;
            r_z_reg     <= '0;
            r_id_reg    <= ID_A;
        end else begin
            state_reg   <= state_next;
            r_valid_reg <= r_valid_next;
            r_z_reg     <= r_z_next;
            r_id_reg    <= r_id_next;
        end
    end

    assign A_READY = a_grant;
    assign B_READY = b_grant;
    assign R_VALID = r_valid_reg;
    assign R_Z     = r_z_reg;
    assign R_ID    = r_id_reg;
    assign BUSY    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_alu_rr_sched.sv
// Self-checking bench for alu_rr_sched: directed steps plus random traffic
// checked against a transaction-level timing and arithmetic model.
module tb_alu_rr_sched;

`ifdef ALU_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam int INTERVAL = FAST ? 2 : 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       A_VALID = 1'b0, B_VALID = 1'b0, R_READY = 1'b0;
    logic       A_READY, B_READY, R_VALID, R_ID, BUSY;
    logic [2:0] A_X = '0, A_Y = '0, B_X = '0, B_Y = '0;
    logic [1:0] A_OP = '0, B_OP = '0;
    logic [5:0] R_Z;

    alu_rr_sched dut (
        .CLK(CLK), .RST(RST),
        .A_VALID(A_VALID), .A_READY(A_READY), .A_X(A_X), .A_Y(A_Y), .A_OP(A_OP),
        .B_VALID(B_VALID), .B_READY(B_READY), .B_X(B_X), .B_Y(B_Y), .B_OP(B_OP),
        .R_VALID(R_VALID), .R_READY(R_READY), .R_Z(R_Z), .R_ID(R_ID), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference model state: one operation in flight at most
    bit         m_in_flight = 1'b0;
    int         m_acc_cyc = 0;
    bit         m_pri = 1'b0;
    logic [5:0] m_z = '0;
    logic       m_id = 1'b0;
    bit         acc_a, acc_b;
    bit         track = 1'b0;
    int         last_acc = -1;
    logic [5:0] obs_last_z = '0;
    logic       obs_last_id = 1'b0;
    int         acc_ids[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [5:0] ref_f(input logic [1:0] op, input int x, input int y);
        case (op)
            2'd0:    return 6'(x + y);
            2'd1:    return 6'(x * y);
            2'd2:    return 6'(x & y);
            default: return 6'(x | y);
        endcase
    endfunction

    task automatic check_cycle();
        bit exp_rv, allow, ga, gb;
        @(negedge CLK);
        cyc++;
        exp_rv = m_in_flight && (cyc >= m_acc_cyc + 2);
        allow  = !m_in_flight || (FAST && exp_rv && R_READY);
        ga = allow && A_VALID && (!B_VALID || !m_pri);
        gb = allow && B_VALID && (!A_VALID || m_pri);
        chk("a_ready", 32'(A_READY), 32'(ga));
        chk("b_ready", 32'(B_READY), 32'(gb));
        chk("r_valid", 32'(R_VALID), 32'(exp_rv));
        chk("busy", 32'(BUSY), 32'(m_in_flight));
        if (exp_rv) begin
            chk("r_z", 32'(R_Z), 32'(m_z));
            chk("r_id", 32'(R_ID), 32'(m_id));
        end
        if (exp_rv && R_READY) begin
            m_in_flight = 1'b0;
            obs_last_z  = R_Z;
            obs_last_id = R_ID;
            $display("cycle %0d: result id=%0d z=%0d", cyc, R_ID, R_Z);
        end
        acc_a = ga;
        acc_b = gb;
        if (ga || gb) begin
            m_z  = gb ? ref_f(B_OP, int'(B_X), int'(B_Y)) : ref_f(A_OP, int'(A_X), int'(A_Y));
            m_id = gb;
            m_pri = ga;
            m_in_flight = 1'b1;
            m_acc_cyc = cyc;
            if (track) begin
                if (last_acc >= 0) chk("accept_interval", 32'(cyc - last_acc), 32'(INTERVAL));
                acc_ids.push_back(int'(gb));
            end
            last_acc = cyc;
        end
    endtask

    task automatic cycle();
        check_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        A_VALID = 1'b0; B_VALID = 1'b0; R_READY = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_r_valid", 32'(R_VALID), 32'd0);
        chk("rst_r_z", 32'(R_Z), 32'd0);
        chk("rst_r_id", 32'(R_ID), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        m_in_flight = 1'b0;
        m_pri = 1'b0;
    endtask

    task automatic run_single(input bit use_b, input logic [2:0] x, input logic [2:0] y,
                              input logic [1:0] op);
        R_READY = 1'b1;
        if (use_b) begin
            B_VALID = 1'b1; B_X = x; B_Y = y; B_OP = op;
        end else begin
            A_VALID = 1'b1; A_X = x; A_Y = y; A_OP = op;
        end
        cycle();
        chk("single_accept", 32'(acc_a | acc_b), 32'd1);
        A_VALID = 1'b0; B_VALID = 1'b0;
        cycle(); cycle(); cycle();
    endtask

    task automatic new_a();
        A_X = 3'($urandom_range(0, 7)); A_Y = 3'($urandom_range(0, 7));
        A_OP = 2'($urandom_range(0, 3));
    endtask

    task automatic new_b();
        B_X = 3'($urandom_range(0, 7)); B_Y = 3'($urandom_range(0, 7));
        B_OP = 2'($urandom_range(0, 3));
    endtask

    initial begin
        do_reset();

        // A alone, then B alone through every opcode
        run_single(1'b0, 3'd3, 3'd5, 2'b00);
        chk("a_add_z", 32'(obs_last_z), 32'd8);
        chk("a_add_id", 32'(obs_last_id), 32'd0);
        run_single(1'b1, 3'd7, 3'd7, 2'b01);
        chk("b_mul_z", 32'(obs_last_z), 32'd49);
        chk("b_mul_id", 32'(obs_last_id), 32'd1);
        run_single(1'b1, 3'd6, 3'd3, 2'b10);
        chk("b_and_z", 32'(obs_last_z), 32'd2);
        run_single(1'b1, 3'd6, 3'd3, 2'b11);
        chk("b_or_z", 32'(obs_last_z), 32'd7);

        // both continuously valid from reset: alternating grants at full rate
        do_reset();
        R_READY = 1'b1;
        track = 1'b1; last_acc = -1; acc_ids.delete();
        new_a(); new_b();
        A_VALID = 1'b1; B_VALID = 1'b1;
        for (int i = 0; i < 24; i++) begin
            cycle();
            if (acc_a) new_a();
            if (acc_b) new_b();
        end
        track = 1'b0;
        chk("rr_count_min", 32'(acc_ids.size() >= 4), 32'd1);
        if (acc_ids.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("rr_order", 32'(acc_ids[i]), 32'(i % 2));
        end
        A_VALID = 1'b0; B_VALID = 1'b0;
        for (int i = 0; i < 4; i++) cycle();

        // backpressure: result held for five cycles, then released
        new_a();
        A_VALID = 1'b1;
        cycle();
        A_VALID = 1'b0;
        R_READY = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        R_READY = 1'b1;
        cycle();
        cycle();
        chk("bp_idle_after", 32'(BUSY), 32'd0);

        // reset pulse while an operation is in EXEC
        do_reset();
        R_READY = 1'b1;
        new_a();
        A_VALID = 1'b1;
        cycle();
        new_a(); new_b();
        B_VALID = 1'b1;
        #1 RST = 1'b1;
        #2 RST = 1'b0;
        m_in_flight = 1'b0;
        m_pri = 1'b0;
        chk("mid_rst_r_z", 32'(R_Z), 32'd0);
        chk("mid_rst_busy", 32'(BUSY), 32'd0);
        cycle();
        chk("mid_rst_regrant_a", 32'(acc_a), 32'd1);
        A_VALID = 1'b0; B_VALID = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        chk("mid_rst_followup_id", 32'(obs_last_id), 32'd0);

        // random traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            R_READY = ($urandom_range(0, 99) < 70);
            if (!A_VALID || acc_a) begin
                A_VALID = ($urandom_range(0, 1) == 1);
                new_a();
            end
            if (!B_VALID || acc_b) begin
                B_VALID = ($urandom_range(0, 1) == 1);
                new_b();
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
